keccak_block_padder: RTL and testbench
======================================

Name: keccak_block_padder

Overview:
- Source side of the permutation engine's 576-bit block handshake (in / in_ready / ack).
- Collects 32-bit message words into 576-bit rate blocks (18 words per block).
- Applies Keccak pad10*1 byte padding (0x01 … 0x80) to the final block.
- Presents each completed block to the permutation engine and holds it until acknowledged.

Parameters:
- WORDS, 18, 32-bit words per rate block (576 / 32).
- CW, 5, counter width; must hold 0..WORDS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in  input  32  message word; first byte in in[31:24].
- in_ready  input  1  `in` is valid this cycle.
- is_last  input  1  current word is the final message word.
- byte_num  input  2  valid bytes in the last word (0..3); only meaningful when is_last=1.
- buffer_full  output  1  word not accepted this cycle; source must hold it.
- out  output  576  block to the permutation engine; first word in out[575:544].
- out_ready  output  1  out holds a complete block.
- f_ack  input  1  permutation engine has consumed out.

Behaviour:
- Reset values: out=0, out_ready=0, buffer_full=0, count=0, state=ACCUM.
- Storage: out is a shift register. Each loaded word shifts in at out[31:0] and moves older contents up 32 bits.
- Counter: count = number of words loaded into the current block.
- out_ready is registered and equals (count==WORDS).
- States:
  - ACCUM: accepts a word when in_ready=1 and buffer_full=0. Shift it in, count+1.
    - If is_last=1, shift in the padded word instead and go to PAD; done flag set.
  - PAD: each cycle shift in 32'h00000000 and count+1 until count reaches WORDS. No input accepted.
  - FULL (count==WORDS): hold out stable. On f_ack=1, count<=0 next cycle.
    - If done is clear, next state is ACCUM.
    - If done is set, next state is DONE.
  - DONE: terminal. Inputs ignored, out_ready=0, buffer_full=1 until reset.
- buffer_full = (state!=ACCUM) | out_ready. It is combinational from registered state only.
- Padded last word by byte_num:
  - 0 → 32'h01000000
  - 1 → {in[31:24],24'h010000}
  - 2 → {in[31:16],16'h0100}
  - 3 → {in[31:8],8'h01}
- Final-bit rule: in the final block, the word entering slot WORDS-1 (the word loaded when count==WORDS-1) is ORed with 32'h00000080.
  - This applies whether that word is a pad word or the padded last word.
  - Example: last word in slot 17 with byte_num=3 gives low byte 0x81.
- Message length a multiple of 4 bytes: the source sends an extra is_last word with byte_num=0.
- Message exactly filling a block: the is_last word starts a new block, so the padding occupies a whole block.
- Latency:
  - 18th word accepted at edge N → out_ready=1 after edge N.
  - is_last word loaded into slot k at edge N → out_ready=1 after edge N+(17-k).
- Simultaneous events:
  - f_ack while out_ready=0 is ignored.
  - in_ready while buffer_full=1 is ignored; no word is consumed.
  - The cycle f_ack is seen, no word is accepted; accepting resumes the following cycle.
- is_last with in_ready=0 is ignored.
- Reset asserted mid-block or mid-PAD: all registers clear immediately without waiting for a clock edge; a partial block is discarded.

Test Plan:
1. Empty message: cycle 0 in_ready=1, is_last=1, byte_num=0.
   → out_ready after 18 edges; out = {32'h01000000, 16×32'h0, 32'h00000080}; buffer_full=1 during PAD.
2. Eighteen words 0x00000001..0x00000012, then f_ack, then is_last byte_num=0.
   → Block 1: out[575:544]=0x1, out[31:0]=0x12, no 0x80.
   → Block 2: {32'h01000000, 16×0, 32'h80}.
3. 17 full words, then in=0xAABBCCDD with is_last=1 and byte_num=3 (slot 17).
   → out_ready the next cycle; out[31:0]=0xAABBCC81.
4. Backpressure: out_ready=1, f_ack=0 for 10 cycles, in_ready=1 held.
   → buffer_full=1 throughout, out unchanged, no word consumed; f_ack pulse → count=0, buffer_full=0 next cycle.
5. Asynchronous reset pulse between edges after 9 words accepted.
   → out=0, out_ready=0, buffer_full=0 before the next edge; a new message then packs from slot 0.
6. After the final block is acked (DONE state): in_ready=1 with words for 5 cycles.
   → buffer_full=1, out_ready stays 0, out unchanged; reset returns to ACCUM.

Source files
------------

// File: rtl/keccak_block_padder.sv
// Packs 32-bit message words into 576-bit Keccak rate blocks, applies pad10*1
// byte padding to the final block and holds each block until the engine acks it.
module keccak_block_padder #(
  parameter int unsigned WORDS = 18,
  parameter int unsigned CW    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           in,
  input  logic                  in_ready,
  input  logic                  is_last,
  input  logic [1:0]            byte_num,
  output logic                  buffer_full,
  output logic [32*WORDS-1:0]   out,
  output logic                  out_ready,
  input  logic                  f_ack
);

  typedef enum logic [1:0] {StAccum, StPad, StFull, StDone} state_e;

  localparam logic [CW-1:0] LastSlot = CW'(WORDS - 1);

  state_e          state_q;
  logic [CW-1:0]   count_q;
  logic            done_q;
  logic [31:0]     final_bit;
  logic [31:0]     last_word;

  always_comb begin
    // Closing 1 of pad10*1 lands in the word that fills the last slot.
    final_bit = (count_q == LastSlot) ? 32'h0000_0080 : 32'h0;
    last_word = 32'h0;
    unique case (byte_num)
      2'd0: last_word = 32'h0100_0000;
      2'd1: last_word = {in[31:24], 24'h01_0000};
      2'd2: last_word = {in[31:16], 16'h0100};
      2'd3: last_word = {in[31:8], 8'h01};
      default: last_word = 32'h0;
    endcase
    last_word = last_word | final_bit;
  end

  assign buffer_full = (state_q != StAccum) | out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StAccum;
      count_q   <= '0;
      done_q    <= 1'b0;
      out       <= '0;
      out_ready <= 1'b0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (in_ready && !buffer_full) begin
            out     <= {out[32*WORDS-33:0], (is_last ? last_word : in)};
            count_q <= count_q + CW'(1);
            if (is_last) begin
              done_q <= 1'b1;
            end
            if (count_q == LastSlot) begin
              state_q   <= StFull;
              out_ready <= 1'b1;
            end else if (is_last) begin
              state_q <= StPad;
            end
          end
        end
        StPad: begin
          out     <= {out[32*WORDS-33:0], final_bit};
          count_q <= count_q + CW'(1);
          if (count_q == LastSlot) begin
            state_q   <= StFull;
            out_ready <= 1'b1;
          end
        end
        StFull: begin
          if (f_ack) begin
            count_q   <= '0;
            out_ready <= 1'b0;
            state_q   <= done_q ? StDone : StAccum;
          end
        end
        StDone: begin
        end
        default: state_q <= StAccum;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_block_padder.sv
// Directed bench for keccak_block_padder: packing, padding, backpressure,
// asynchronous reset and the terminal state.
module tb_keccak_block_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  in;
  logic         in_ready;
  logic         is_last;
  logic [1:0]   byte_num;
  logic         buffer_full;
  logic [575:0] out;
  logic         out_ready;
  logic         f_ack;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [575:0] exp_blk;
  logic [575:0] blk_save;

  keccak_block_padder #(
    .WORDS(18),
    .CW   (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .in_ready   (in_ready),
    .is_last    (is_last),
    .byte_num   (byte_num),
    .buffer_full(buffer_full),
    .out        (out),
    .out_ready  (out_ready),
    .f_ack      (f_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic word(input logic [31:0] w, input logic last, input logic [1:0] bn);
    in       = w;
    in_ready = 1'b1;
    is_last  = last;
    byte_num = bn;
    tick();
    in_ready = 1'b0;
    is_last  = 1'b0;
  endtask

  task automatic ack();
    f_ack = 1'b1;
    tick();
    f_ack = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in = '0; in_ready = 1'b0; is_last = 1'b0; byte_num = '0; f_ack = 1'b0;
    #12;
    chk("rst_out", out, '0);
    chk("rst_out_ready", {575'b0, out_ready}, 576'd0);
    chk("rst_buffer_full", {575'b0, buffer_full}, 576'd0);
    reset = 1'b0;
    tick();

    // 1: empty message, padding fills a whole block
    word(32'hDEAD_BEEF, 1'b1, 2'd0);
    chk("t1_pad_bf", {575'b0, buffer_full}, 576'd1);
    chk("t1_pad_or", {575'b0, out_ready}, 576'd0);
    for (int i = 0; i < 16; i++) tick();
    chk("t1_edge17_or", {575'b0, out_ready}, 576'd0);
    tick();
    chk("t1_edge18_or", {575'b0, out_ready}, 576'd1);
    exp_blk = {32'h0100_0000, 512'h0, 32'h0000_0080};
    chk("t1_blk", out, exp_blk);

    // 6: after ack of the final block the padder is terminal
    ack();
    chk("t6_done_or", {575'b0, out_ready}, 576'd0);
    for (int i = 0; i < 5; i++) begin
      in = 32'h5555_0000 + 32'(i); in_ready = 1'b1;
      tick();
    end
    in_ready = 1'b0;
    chk("t6_done_bf", {575'b0, buffer_full}, 576'd1);
    chk("t6_done_or2", {575'b0, out_ready}, 576'd0);
    chk("t6_done_out", out, exp_blk);
    pulse_reset();
    chk("t6_rst_bf", {575'b0, buffer_full}, 576'd0);
    chk("t6_rst_out", out, '0);
    tick();

    // 2: eighteen words exactly fill block 1; f_ack before full is ignored
    exp_blk = '0;
    f_ack = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      exp_blk = {exp_blk[543:0], 32'(i)};
      in = 32'(i); in_ready = 1'b1; is_last = 1'b0;
      if (i == 18) chk("t2_pre_or", {575'b0, out_ready}, 576'd0);
      tick();
      if (i == 3) f_ack = 1'b0;
    end
    chk("t2_b1_or", {575'b0, out_ready}, 576'd1);
    chk("t2_b1_out", out, exp_blk);
    chk("t2_b1_first", {544'b0, out[575:544]}, 576'h1);
    chk("t2_b1_lastw", {544'b0, out[31:0]}, 576'h12);

    // 4: backpressure with in_ready held high
    in = 32'hBAD0_BAD0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_bf", {575'b0, buffer_full}, 576'd1);
    end
    chk("t4_out_hold", out, exp_blk);
    in_ready = 1'b0;
    ack();
    chk("t4_ack_bf", {575'b0, buffer_full}, 576'd0);
    chk("t4_ack_or", {575'b0, out_ready}, 576'd0);
    word(32'h1234_5678, 1'b1, 2'd0);
    for (int i = 0; i < 17; i++) tick();
    chk("t2_b2_or", {575'b0, out_ready}, 576'd1);
    chk("t2_b2_out", out, {32'h0100_0000, 512'h0, 32'h0000_0080});
    ack();
    pulse_reset();
    tick();

    // 3: last word lands in slot 17, carries both pad bits
    exp_blk = '0;
    for (int i = 0; i < 17; i++) begin
      exp_blk = {exp_blk[543:0], 32'h1000_0000 + 32'(i)};
      word(32'h1000_0000 + 32'(i), 1'b0, 2'd0);
    end
    exp_blk = {exp_blk[543:0], 32'hAABB_CC81};
    word(32'hAABB_CCDD, 1'b1, 2'd3);
    chk("t3_or", {575'b0, out_ready}, 576'd1);
    chk("t3_low", {544'b0, out[31:0]}, {544'b0, 32'hAABB_CC81});
    chk("t3_blk", out, exp_blk);
    ack();
    chk("t3_done_bf", {575'b0, buffer_full}, 576'd1);
    pulse_reset();
    tick();

    // 5: async reset mid-block; is_last without in_ready is ignored
    for (int i = 0; i < 9; i++) word(32'hC000_0000 + 32'(i), 1'b0, 2'd0);
    is_last = 1'b1; byte_num = 2'd1;
    tick();
    is_last = 1'b0;
    chk("t5_islast_noready_bf", {575'b0, buffer_full}, 576'd0);
    blk_save = out;
    chk("t5_islast_noready_low", {544'b0, blk_save[31:0]}, {544'b0, 32'hC000_0008});
    pulse_reset();
    chk("t5_rst_out", out, '0);
    chk("t5_rst_or", {575'b0, out_ready}, 576'd0);
    chk("t5_rst_bf", {575'b0, buffer_full}, 576'd0);
    tick();
    word(32'h1234_5678, 1'b1, 2'd2);
    for (int i = 0; i < 17; i++) tick();
    chk("t5_new_or", {575'b0, out_ready}, 576'd1);
    chk("t5_new_blk", out, {32'h1234_0100, 512'h0, 32'h0000_0080});
    pulse_reset();
    tick();

    // byte_num=1 last word in slot 5: out_ready 12 edges later
    exp_blk = '0;
    for (int i = 0; i < 5; i++) begin
      exp_blk = {exp_blk[543:0], 32'hE000_0000 + 32'(i)};
      word(32'hE000_0000 + 32'(i), 1'b0, 2'd0);
    end
    exp_blk = {exp_blk[543:0], 32'hCA01_0000, 352'h0, 32'h0000_0080};
    word(32'hCAFE_F00D, 1'b1, 2'd1);
    for (int i = 0; i < 11; i++) tick();
    chk("t7_edge11_or", {575'b0, out_ready}, 576'd0);
    tick();
    chk("t7_edge12_or", {575'b0, out_ready}, 576'd1);
    chk("t7_blk", out, exp_blk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
